// File: rtl/mop_adder_pipe_if.sv
// Operand/result handshake bundle for mop_adder_pipe.
// The master drives operand sets and accepts results; the slave is the adder.
interface mop_adder_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_OPS = 7,
    parameter int unsigned EXT   = $clog2(N_OPS)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OPS*WIDTH-1:0] in_ops;
    logic [N_OPS-1:0]       in_mask;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       sum;
    logic [EXT-1:0]         sum_hi;
    logic                   ovfl;

    modport master (
        output in_valid, in_ops, in_mask, out_ready,
        input  in_ready, out_valid, sum, sum_hi, ovfl
    );

    modport slave (
        input  in_valid, in_ops, in_mask, out_ready,
        output in_ready, out_valid, sum, sum_hi, ovfl
    );
endinterface

// File: rtl/mop_adder_pipe.sv
// Two-stage multi-operand modular adder: carry-save reduction, then carry-propagate add.
// Every stage is WIDTH+EXT bits wide, which makes the overflow count in sum_hi exact.
module mop_adder_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N_OPS = 7,
    parameter int unsigned EXT   = $clog2(N_OPS)
) (
    input  logic            clk,
    input  logic            rst,
    mop_adder_pipe_if.slave bus
);
    localparam int unsigned XW = WIDTH + EXT;

    logic          w_s1_adv;
    logic          w_s2_adv;
    logic [XW-1:0] w_vs;
    logic [XW-1:0] w_vc;
    logic [XW-1:0] w_add;

    logic          r_s1_valid;
    logic          r_s2_valid;
    logic          r_ovfl;
    logic [XW-1:0] r_vs;
    logic [XW-1:0] r_vc;
    logic [XW-1:0] r_sum;

    // Wallace-style 3:2 reduction. Each level compresses groups of three vectors into two,
    // and leftovers pass through. The total stays below 2^XW, so dropping the carry MSB is exact.
    always_comb begin : p_csa
        logic [XW-1:0] v [N_OPS];
        logic [XW-1:0] t [N_OPS];
        int            n;
        int            g;
        int            r;
        n = N_OPS;
        g = 0;
        r = 0;
        for (int i = 0; i < N_OPS; i++) begin
            t[i] = '0;
            v[i] = bus.in_mask[i] ? XW'(bus.in_ops[i*WIDTH +: WIDTH]) : '0;
        end
        for (int lv = 0; lv < N_OPS; lv++) begin
            if (n > 2) begin
                g = n / 3;
                r = n % 3;
                for (int i = 0; i < N_OPS; i++) begin
                    t[i] = '0;
                end
                for (int k = 0; k < N_OPS / 3; k++) begin
                    if (k < g) begin
                        t[2*k]   = v[3*k] ^ v[3*k+1] ^ v[3*k+2];
                        t[2*k+1] = ((v[3*k] & v[3*k+1]) | (v[3*k] & v[3*k+2]) |
                                    (v[3*k+1] & v[3*k+2])) << 1;
                    end
                end
                for (int j = 0; j < 2; j++) begin
                    if (j < r) begin
                        t[2*g+j] = v[3*g+j];
                    end
                end
                v = t;
                n = 2*g + r;
            end
        end
        w_vs = v[0];
        w_vc = v[1];
    end

    // Pipeline advance: a stage may load when it is empty or its contents move on this cycle.
    assign w_s2_adv = !r_s2_valid || bus.out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_add    = r_vs + r_vc;

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_s2_valid;
    assign bus.sum       = r_sum[WIDTH-1:0];
    assign bus.sum_hi    = r_sum[XW-1:WIDTH];
    assign bus.ovfl      = r_ovfl;

    // Data registers load only with a valid set, so the result stays put through bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_ovfl     <= 1'b0;
            r_vs       <= '0;
            r_vc       <= '0;
            r_sum      <= '0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_sum  <= w_add;
                    r_ovfl <= |w_add[XW-1:WIDTH];
                end
            end
            if (w_s1_adv) begin
                r_s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    r_vs <= w_vs;
                    r_vc <= w_vc;
                end
            end
        end
    end
endmodule

// File: tb/tb_mop_adder_pipe.sv
// Bench for mop_adder_pipe: directed cases on the 7x32 build plus a randomized sweep
// of 8-bit builds with 2, 3 and 16 operands, checked against an exact-sum reference model.
module tb_mop_adder_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mop_adder_pipe_if #(.WIDTH(32), .N_OPS(7))  if_m ();
    mop_adder_pipe_if #(.WIDTH(8),  .N_OPS(2))  if_a ();
    mop_adder_pipe_if #(.WIDTH(8),  .N_OPS(3))  if_b ();
    mop_adder_pipe_if #(.WIDTH(8),  .N_OPS(16)) if_c ();

    mop_adder_pipe #(.WIDTH(32), .N_OPS(7))  u_dut (.clk(clk), .rst(rst), .bus(if_m));
    mop_adder_pipe #(.WIDTH(8),  .N_OPS(2))  u_d2  (.clk(clk), .rst(rst), .bus(if_a));
    mop_adder_pipe #(.WIDTH(8),  .N_OPS(3))  u_d3  (.clk(clk), .rst(rst), .bus(if_b));
    mop_adder_pipe #(.WIDTH(8),  .N_OPS(16)) u_d16 (.clk(clk), .rst(rst), .bus(if_c));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] q    [4][$];
    logic        hold [4];
    logic [63:0] held [4];
    int          recv [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Exact masked sum with plain arithmetic.
    function automatic logic [63:0] exact(input logic [511:0] ops, input logic [15:0] mask,
                                          input int n, input int w);
        logic [63:0]  acc;
        logic [511:0] lim;
        acc = 64'd0;
        lim = (512'd1 << w) - 512'd1;
        for (int i = 0; i < n; i++) begin
            if (mask[i]) acc = acc + 64'((ops >> (i*w)) & lim);
        end
        return acc;
    endfunction

    // Scoreboard step for one DUT, called once per cycle after inputs settle.
    // A pipeline holds at most two sets, so ready must drop only with two pending and no drain.
    task automatic observe(input int id, input string tag, input int w,
                           input logic iv, input logic ir, input logic ov, input logic orr,
                           input logic [63:0] val, input logic ovf, input logic [63:0] exp_in);
        logic [63:0] head;
        check({tag, " in_ready"}, 64'(ir), 64'(!(q[id].size() == 2 && !orr)));
        check({tag, " spurious"}, 64'(ov && q[id].size() == 0), 64'd0);
        if (hold[id]) begin
            check({tag, " hold_valid"}, 64'(ov), 64'd1);
            check({tag, " hold_data"}, val, held[id]);
        end
        if (ov && orr && q[id].size() > 0) begin
            head = q[id].pop_front();
            recv[id]++;
            check({tag, " result"}, val, head);
            check({tag, " ovfl"}, 64'(ovf), 64'((head >> w) != 64'd0));
        end
        hold[id] = ov && !orr;
        held[id] = val;
        if (iv && ir) q[id].push_back(exp_in);
    endtask

    task automatic single(input string tag, input logic [223:0] ops, input logic [6:0] mask,
                          input logic [31:0] e_sum, input logic [2:0] e_hi, input logic e_ov);
        tick();
        if_m.in_valid  = 1'b1;
        if_m.in_ops    = ops;
        if_m.in_mask   = mask;
        if_m.out_ready = 1'b1;
        #1;
        check({tag, " accept"}, 64'(if_m.in_ready), 64'd1);
        tick();
        if_m.in_valid = 1'b0;
        if_m.in_ops   = {7{$urandom}};
        if_m.in_mask  = 7'($urandom);
        #1;
        check({tag, " early_valid"}, 64'(if_m.out_valid), 64'd0);
        tick();
        check({tag, " valid"}, 64'(if_m.out_valid), 64'd1);
        check({tag, " sum"}, 64'(if_m.sum), 64'(e_sum));
        check({tag, " sum_hi"}, 64'(if_m.sum_hi), 64'(e_hi));
        check({tag, " ovfl"}, 64'(if_m.ovfl), 64'(e_ov));
        tick();
        check({tag, " drained"}, 64'(if_m.out_valid), 64'd0);
    endtask

    initial begin
        logic [223:0] ops;
        int           k;
        int           base;
        logic         acc;

        for (int i = 0; i < 4; i++) begin
            hold[i] = 1'b0;
            held[i] = 64'd0;
            recv[i] = 0;
        end
        rst = 1'b1;
        if_m.in_valid = 1'b0; if_m.in_ops = '0; if_m.in_mask = '0; if_m.out_ready = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_ops = '0; if_a.in_mask = '0; if_a.out_ready = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_ops = '0; if_b.in_mask = '0; if_b.out_ready = 1'b0;
        if_c.in_valid = 1'b0; if_c.in_ops = '0; if_c.in_mask = '0; if_c.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset out_valid", 64'(if_m.out_valid), 64'd0);
        check("reset in_ready", 64'(if_m.in_ready), 64'd1);
        check("reset sum", 64'(if_m.sum), 64'd0);
        check("reset sum_hi", 64'(if_m.sum_hi), 64'd0);
        check("reset ovfl", 64'(if_m.ovfl), 64'd0);

        // Directed operand sets
        for (int i = 0; i < 7; i++) ops[i*32 +: 32] = 32'(i + 1);
        single("seq1to7", ops, 7'h7F, 32'h0000_001C, 3'd0, 1'b0);
        ops = '1;
        single("allones", ops, 7'h7F, 32'hFFFF_FFF9, 3'd6, 1'b1);
        single("mask05", ops, 7'h05, 32'hFFFF_FFFE, 3'd1, 1'b1);
        single("mask0", ops, 7'h00, 32'h0000_0000, 3'd0, 1'b0);

        // Streaming with a four-cycle output stall
        k    = 0;
        base = recv[0];
        for (int c = 0; c < 40; c++) begin
            tick();
            if_m.out_ready = !(c >= 3 && c <= 6);
            if_m.in_valid  = (k < 10);
            if_m.in_ops    = 224'(k);
            if_m.in_mask   = 7'h7F;
            #1;
            if (c == 5) begin
                check("stream stall in_ready", 64'(if_m.in_ready), 64'd0);
                check("stream stall sum", 64'(if_m.sum), 64'd1);
            end
            acc = if_m.in_valid && if_m.in_ready;
            observe(0, "stream", 32, if_m.in_valid, if_m.in_ready, if_m.out_valid,
                    if_m.out_ready, 64'({if_m.sum_hi, if_m.sum}), if_m.ovfl,
                    exact(512'(if_m.in_ops), 16'(if_m.in_mask), 7, 32));
            if (acc) k++;
            if (k == 10 && q[0].size() == 0) break;
        end
        if_m.in_valid = 1'b0;
        check("stream accepted", 64'(k), 64'd10);
        check("stream delivered", 64'(recv[0] - base), 64'd10);

        // Reset with both stages full
        tick();
        if_m.out_ready = 1'b0;
        if_m.in_valid  = 1'b1;
        if_m.in_ops    = 224'h0AA;
        if_m.in_mask   = 7'h01;
        tick();
        if_m.in_ops    = 224'h0BB;
        tick();
        if_m.in_valid  = 1'b0;
        #1;
        check("full out_valid", 64'(if_m.out_valid), 64'd1);
        check("full in_ready", 64'(if_m.in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst out_valid", 64'(if_m.out_valid), 64'd0);
        check("midrst in_ready", 64'(if_m.in_ready), 64'd1);
        check("midrst sum", 64'(if_m.sum), 64'd0);
        check("midrst sum_hi", 64'(if_m.sum_hi), 64'd0);
        check("midrst ovfl", 64'(if_m.ovfl), 64'd0);
        if_m.in_valid  = 1'b1;
        if_m.in_ops    = {160'd0, 32'h20, 32'h10};
        if_m.in_mask   = 7'h7F;
        if_m.out_ready = 1'b1;
        tick();
        if_m.in_valid  = 1'b0;
        #1;
        check("post_rst no_stale", 64'(if_m.out_valid), 64'd0);
        tick();
        check("post_rst valid", 64'(if_m.out_valid), 64'd1);
        check("post_rst sum", 64'(if_m.sum), 64'h30);
        tick();
        check("post_rst drained", 64'(if_m.out_valid), 64'd0);

        // Randomized sweep of the 8-bit builds
        for (int c = 0; c < 400; c++) begin
            tick();
            if_a.in_valid  = ($urandom_range(0, 3) != 0);
            if_a.out_ready = ($urandom_range(0, 3) != 0);
            if_b.in_valid  = ($urandom_range(0, 3) != 0);
            if_b.out_ready = ($urandom_range(0, 3) != 0);
            if_c.in_valid  = ($urandom_range(0, 3) != 0);
            if_c.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                if_a.in_ops = '1; if_a.in_mask = '1;
                if_b.in_ops = '1; if_b.in_mask = '1;
                if_c.in_ops = '1; if_c.in_mask = '1;
            end else begin
                if_a.in_ops  = 16'($urandom);
                if_a.in_mask = 2'($urandom);
                if_b.in_ops  = 24'($urandom);
                if_b.in_mask = 3'($urandom);
                if_c.in_ops  = {$urandom, $urandom, $urandom, $urandom};
                if_c.in_mask = 16'($urandom);
            end
            #1;
            observe(1, "n2", 8, if_a.in_valid, if_a.in_ready, if_a.out_valid, if_a.out_ready,
                    64'({if_a.sum_hi, if_a.sum}), if_a.ovfl,
                    exact(512'(if_a.in_ops), 16'(if_a.in_mask), 2, 8));
            observe(2, "n3", 8, if_b.in_valid, if_b.in_ready, if_b.out_valid, if_b.out_ready,
                    64'({if_b.sum_hi, if_b.sum}), if_b.ovfl,
                    exact(512'(if_b.in_ops), 16'(if_b.in_mask), 3, 8));
            observe(3, "n16", 8, if_c.in_valid, if_c.in_ready, if_c.out_valid, if_c.out_ready,
                    64'({if_c.sum_hi, if_c.sum}), if_c.ovfl,
                    exact(512'(if_c.in_ops), 16'(if_c.in_mask), 16, 8));
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            if_a.in_valid = 1'b0; if_a.out_ready = 1'b1;
            if_b.in_valid = 1'b0; if_b.out_ready = 1'b1;
            if_c.in_valid = 1'b0; if_c.out_ready = 1'b1;
            #1;
            observe(1, "n2", 8, if_a.in_valid, if_a.in_ready, if_a.out_valid, if_a.out_ready,
                    64'({if_a.sum_hi, if_a.sum}), if_a.ovfl, 64'd0);
            observe(2, "n3", 8, if_b.in_valid, if_b.in_ready, if_b.out_valid, if_b.out_ready,
                    64'({if_b.sum_hi, if_b.sum}), if_b.ovfl, 64'd0);
            observe(3, "n16", 8, if_c.in_valid, if_c.in_ready, if_c.out_valid, if_c.out_ready,
                    64'({if_c.sum_hi, if_c.sum}), if_c.ovfl, 64'd0);
        end
        check("n2 drained", 64'(q[1].size()), 64'd0);
        check("n3 drained", 64'(q[2].size()), 64'd0);
        check("n16 drained", 64'(q[3].size()), 64'd0);
        check("n16 got results", 64'(recv[3] > 100), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
